// File: rtl/shrg_tx_if.sv
// rtl/shrg_tx_if.sv - parallel-in / serial-out transmitter bus: word write, bit tick, serial strobes
interface shrg_tx_if #(
    parameter int N = 8
);
    logic [N-1:0] i;
    logic         wri;
    logic         tick;
    logic         rdy;
    logic         data;
    logic         shift;
    logic         set;
    logic         busy;
    logic         ovr;

    modport master (
        output i,
        output wri,
        output tick,
        input  rdy,
        input  data,
        input  shift,
        input  set,
        input  busy,
        input  ovr
    );

    modport slave (
        input  i,
        input  wri,
        input  tick,
        output rdy,
        output data,
        output shift,
        output set,
        output busy,
        output ovr
    );
endinterface

// File: rtl/shrg_tx.sv
// rtl/shrg_tx.sv - double-buffered shift-register transmitter, MSB first, with shift/set strobes
module shrg_tx #(
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     reset,
    shrg_tx_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  hold;
    logic          hold_valid;
    logic [N-1:0]  sr;
    logic [CW-1:0] cnt;
    logic          data_q;
    logic          shift_q;
    logic          set_q;
    logic          ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            data_q     <= 1'b0;
            shift_q    <= 1'b0;
            set_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            // Accept and transfer are disjoint: accept needs hold empty, transfer needs it full.
            if (bus.wri) begin
                if (!hold_valid) begin
                    hold       <= bus.i;
                    hold_valid <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end

            shift_q <= 1'b0;
            set_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        sr         <= hold;
                        hold_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.tick) begin
                        data_q  <= sr[N-1];
                        sr      <= {sr[N-2:0], 1'b0};
                        shift_q <= 1'b1;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= LATCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    set_q <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdy   = ~hold_valid;
    assign bus.busy  = (state != IDLE);
    assign bus.data  = data_q;
    assign bus.shift = shift_q;
    assign bus.set   = set_q;
    assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_shrg_tx.sv
// tb/tb_shrg_tx.sv - directed self-checking bench for shrg_tx with a looped-back serial receiver
module tb_shrg_tx;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shrg_tx_if #(.N(N)) bus ();
    shrg_tx #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_mode = 0;
    int tcnt = 0;

    logic [N-1:0] rx_sr = '0;
    logic [N-1:0] rx_out = '0;
    logic         bits[$];
    int           shift_cyc[$];
    int           set_cyc[$];
    logic [N-1:0] rx_words[$];
    int           both_high = 0;
    int           data_changes = 0;
    logic         prev_data = 1'b0;

    // Tick source: constant 1, or one cycle in three.
    initial begin
        bus.tick = 1'b1;
        forever begin
            @(negedge clk);
            tcnt++;
            bus.tick = (tick_mode == 0) ? 1'b1 : ((tcnt % 3) == 0);
        end
    end

    // Receiver model: left-shifting serial-in register latched on set.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            if (bus.shift && bus.set) both_high++;
            if (!bus.shift && (bus.data !== prev_data)) data_changes++;
            if (bus.shift) begin
                bits.push_back(bus.data);
                shift_cyc.push_back(cyc);
                rx_sr = {rx_sr[N-2:0], bus.data};
            end
            if (bus.set) begin
                set_cyc.push_back(cyc);
                rx_out = rx_sr;
                rx_words.push_back(rx_sr);
            end
        end
        prev_data = bus.data;
    end

    task automatic clear_mon();
        bits.delete();
        shift_cyc.delete();
        set_cyc.delete();
        rx_words.delete();
        data_changes = 0;
        both_high = 0;
    endtask

    task automatic write_word(input logic [N-1:0] w, output int e0);
        @(negedge clk);
        bus.i   = w;
        bus.wri = 1'b1;
        @(negedge clk);
        bus.wri = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_sets(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (set_cyc.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (set_cyc.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.wri = 1'b1;
        bus.i   = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy got=%b want=1", bus.rdy); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.data !== 1'b0)  begin errors++; $display("FAIL reset_data got=%b want=0", bus.data); end
        checks++; if (bus.shift !== 1'b0) begin errors++; $display("FAIL reset_shift got=%b want=0", bus.shift); end
        checks++; if (bus.set !== 1'b0)   begin errors++; $display("FAIL reset_set got=%b want=0", bus.set); end
        checks++; if (bus.ovr !== 1'b0)   begin errors++; $display("FAIL reset_ovr got=%b want=0", bus.ovr); end
        bus.wri = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [N-1:0] w;
        int e0;
        bit ok;
        w = 8'hA5;
        clear_mon();
        write_word(w, e0);
        checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL single_rdy_after_accept got=%b want=0", bus.rdy); end
        wait_sets(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=no_set want=set"); end
        checks++; if (bits.size() != N) begin errors++; $display("FAIL single_bit_count got=%0d want=%0d", bits.size(), N); end
        for (int k = 0; k < N && k < bits.size(); k++) begin
            checks++;
            if (bits[k] !== w[N-1-k]) begin errors++; $display("FAIL single_bit%0d got=%b want=%b", k, bits[k], w[N-1-k]); end
            checks++;
            if (shift_cyc[k] != e0 + 2 + k) begin errors++; $display("FAIL single_shift_time%0d got=%0d want=%0d", k, shift_cyc[k], e0 + 2 + k); end
        end
        if (ok) begin
            checks++;
            if (set_cyc[0] != e0 + N + 2) begin errors++; $display("FAIL single_set_time got=%0d want=%0d", set_cyc[0], e0 + N + 2); end
        end
        checks++; if (rx_out !== w) begin errors++; $display("FAIL single_rx got=%h want=%h", rx_out, w); end
        checks++; if (both_high != 0) begin errors++; $display("FAIL single_strobe_overlap got=%0d want=0", both_high); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        int n;
        bit ok;
        clear_mon();
        write_word(8'h3C, e0);
        n = 0;
        while (bus.rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_timeout got=%b want=1", bus.rdy); end
        write_word(8'hC3, e1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_shift got_busy=%b want=1", bus.busy); end
        checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got=%b want=0", bus.ovr); end
        wait_sets(2, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d_sets want=2", set_cyc.size()); end
        checks++; if (bits.size() != 2 * N) begin errors++; $display("FAIL b2b_bit_count got=%0d want=%0d", bits.size(), 2 * N); end
        if (ok && bits.size() == 2 * N) begin
            checks++;
            if (shift_cyc[N] - shift_cyc[N-1] != 3) begin errors++; $display("FAIL b2b_gap got=%0d want=3", shift_cyc[N] - shift_cyc[N-1]); end
            checks++;
            if (set_cyc[0] != shift_cyc[N-1] + 1) begin errors++; $display("FAIL b2b_set_after_last got=%0d want=%0d", set_cyc[0], shift_cyc[N-1] + 1); end
            checks++;
            if (rx_words[0] !== 8'h3C) begin errors++; $display("FAIL b2b_word0 got=%h want=3c", rx_words[0]); end
            checks++;
            if (rx_words[1] !== 8'hC3) begin errors++; $display("FAIL b2b_word1 got=%h want=c3", rx_words[1]); end
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int e0;
        int n;
        bit ok;
        clear_mon();
        write_word(8'h11, e0);
        n = 0;
        while (bus.rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        write_word(8'h22, e0);
        checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL ovr_before got=%b want=0", bus.ovr); end
        write_word(8'hFF, e0);
        checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want=1", bus.ovr); end
        wait_sets(2, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout got=%0d_sets want=2", set_cyc.size()); end
        if (ok) begin
            checks++;
            if (rx_words[0] !== 8'h11) begin errors++; $display("FAIL ovr_word0 got=%h want=11", rx_words[0]); end
            checks++;
            if (rx_words[1] !== 8'h22) begin errors++; $display("FAIL ovr_word1 got=%h want=22", rx_words[1]); end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b want=1", bus.ovr); end
        checks++; if (set_cyc.size() != 2) begin errors++; $display("FAIL ovr_frame_count got=%0d want=2", set_cyc.size()); end
    endtask

    task automatic test_gated_tick();
        logic [N-1:0] w;
        int e0;
        bit ok;
        w = 8'h81;
        tick_mode = 1;
        clear_mon();
        write_word(w, e0);
        wait_sets(1, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gated_timeout got=no_set want=set"); end
        checks++; if (bits.size() != N) begin errors++; $display("FAIL gated_bit_count got=%0d want=%0d", bits.size(), N); end
        for (int k = 0; k < N && k < bits.size(); k++) begin
            checks++;
            if (bits[k] !== w[N-1-k]) begin errors++; $display("FAIL gated_bit%0d got=%b want=%b", k, bits[k], w[N-1-k]); end
        end
        for (int k = 1; k < N && k < shift_cyc.size(); k++) begin
            checks++;
            if (shift_cyc[k] - shift_cyc[k-1] != 3) begin errors++; $display("FAIL gated_spacing%0d got=%0d want=3", k, shift_cyc[k] - shift_cyc[k-1]); end
        end
        checks++; if (data_changes != 0) begin errors++; $display("FAIL gated_data_stable got=%0d want=0", data_changes); end
        checks++; if (rx_out !== w) begin errors++; $display("FAIL gated_rx got=%h want=%h", rx_out, w); end
        tick_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int e0;
        int n;
        bit ok;
        clear_mon();
        write_word(8'hF0, e0);
        n = 0;
        while (bits.size() < 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bits.size() != 4) begin errors++; $display("FAIL midrst_reach4 got=%0d want=4", bits.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.rdy !== 1'b1)   begin errors++; $display("FAIL midrst_rdy got=%b want=1", bus.rdy); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        checks++; if (bus.data !== 1'b0)  begin errors++; $display("FAIL midrst_data got=%b want=0", bus.data); end
        checks++; if (bus.shift !== 1'b0) begin errors++; $display("FAIL midrst_shift got=%b want=0", bus.shift); end
        checks++; if (bus.set !== 1'b0)   begin errors++; $display("FAIL midrst_set got=%b want=0", bus.set); end
        checks++; if (bus.ovr !== 1'b0)   begin errors++; $display("FAIL midrst_ovr got=%b want=0", bus.ovr); end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (set_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_set got=%0d want=0", set_cyc.size()); end
        checks++; if (bits.size() != 4) begin errors++; $display("FAIL midrst_no_more_bits got=%0d want=4", bits.size()); end
        clear_mon();
        write_word(8'h5E, e0);
        wait_sets(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_next_timeout got=no_set want=set"); end
        checks++; if (rx_out !== 8'h5E) begin errors++; $display("FAIL midrst_next_rx got=%h want=5e", rx_out); end
        checks++; if (bits.size() != N) begin errors++; $display("FAIL midrst_next_bits got=%0d want=%0d", bits.size(), N); end
    endtask

    initial begin
        bus.i   = '0;
        bus.wri = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_gated_tick();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shrg_tx.md
SHRG_TX -- requirements
Module: shrg_tx

Interface
REQ-001 Parameter N, default 8: parallel word width and bits per frame; N >= 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 i  input  N  parallel word to transmit.
REQ-005 wri  input  1  write strobe; word on i is offered in every cycle wri=1.
REQ-006 tick  input  1  bit-rate enable; one bit advances per tick cycle in SHIFT.
REQ-007 rdy  output  1  holding buffer empty; rdy = NOT hold_valid (combinational from register).
REQ-008 data  output  1  registered serial bit, MSB first.
REQ-009 shift  output  1  registered one-cycle strobe; data is valid for the receiver to sample in this cycle.
REQ-010 set  output  1  registered one-cycle strobe; the receiver latches its parallel output in this cycle.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 ovr  output  1  sticky overrun flag.

Function
REQ-013 Storage SHALL be a one-word holding register (hold, hold_valid), an N-bit shift register sr, and a bit counter wide enough for 0..N-1.
REQ-014 Write accept: wri=1 AND rdy=1 at posedge SHALL capture i into hold and set hold_valid.
REQ-015 Write reject: wri=1 AND rdy=0 SHALL leave hold unchanged and set ovr=1; ovr clears only on reset.
REQ-016 FSM states SHALL be IDLE, SHIFT and LATCH.
REQ-017 IDLE with hold_valid=1: sr <= hold, hold_valid <= 0, cnt <= 0, go to SHIFT; otherwise stay in IDLE.
REQ-018 SHIFT with tick=1: data <= sr[N-1], sr <= sr << 1, shift <= 1, cnt <= cnt+1; if cnt == N-1, go to LATCH.
REQ-019 SHIFT with tick=0: sr, cnt and data hold their values; shift <= 0.
REQ-020 LATCH: set <= 1, shift <= 0, go to IDLE unconditionally; tick is ignored.
REQ-021 shift and set SHALL be 0 in every cycle not named in REQ-018/REQ-020; they are never high together.
REQ-022 data SHALL hold its last driven bit until the next tick in SHIFT.
REQ-023 tick SHALL be ignored in IDLE and LATCH.
REQ-024 A word may be accepted into hold in any state, including SHIFT and LATCH (double buffering).
REQ-025 In the IDLE cycle that transfers hold to sr, rdy=0, so a concurrent wri is rejected per REQ-015.
REQ-026 Latency with tick=1 constant: write accepted at edge E0; sr loads at E1; shift/data first visible after E2; last bit visible after E(N+1); set visible after E(N+2).
REQ-027 Back-to-back frame gap SHALL be exactly 2 non-shift cycles between the last shift pulse and the next frame's first shift pulse (the set cycle, then the IDLE load cycle).
REQ-028 The bit order and strobes SHALL match a left-shifting serial-in receiver, so that after N shift pulses plus one set pulse the receiver's parallel output equals the transmitted word.

Reset
REQ-029 reset=1 at posedge SHALL force: state=IDLE, hold_valid=0 (rdy=1), cnt=0, sr=0, data=0, shift=0, set=0, busy=0, ovr=0.
REQ-030 reset SHALL take priority over wri and tick; a frame interrupted by reset SHALL be discarded with no set pulse.

Verification
REQ-031 Reset: assert reset with wri=1 and tick=1 -> after the edge rdy=1, busy=0, data=shift=set=ovr=0.
REQ-032 Single word: N=8, write 0xA5, tick=1 -> 8 consecutive shift pulses with data 1,0,1,0,0,1,0,1, set on the cycle after the last pulse; looped-back receiver output = 0xA5.
REQ-033 Back-to-back: write 0x3C, then write 0xC3 at the first rdy=1 -> 0xC3 accepted during SHIFT, frames 0x3C then 0xC3 with exactly 2 non-shift cycles between them.
REQ-034 Overrun: hold full, pulse wri with 0xFF -> ovr=1 and stays 1; the transmitted second word is the original held word, not 0xFF.
REQ-035 Gated tick: tick high every 3rd cycle, write 0x81 -> shift pulses spaced 3 cycles apart, data stable between pulses, bits 1,0,0,0,0,0,0,1.
REQ-036 Mid-frame reset: assert reset after 4 shift pulses of 0xF0 -> all outputs return to reset values on the next cycle, no set pulse, and the next written word transmits correctly.
